thmitll_const_src_sync: RTL

// - Clocked, parametrised multi-channel constant/pulse source for RSFQ cell-library test harnesses.
// - Generalises the asynchronous always-0 source: each channel is set to always-0, always-1, periodic or burst mode.
// - Drives stimulus or tie-off nets from a shared clock.
// - Outputs are registered; a logic-1 for one cycle models one SFQ pulse.

---
 rtl/thmitll_const_src_sync_if.sv | 22 ++
 rtl/thmitll_const_src_sync.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/thmitll_const_src_sync_if.sv
// Handshake bundle for the constant/pulse source: mode/period/burst controls in, pulse outputs and busy back.
interface thmitll_const_src_sync_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    logic [2*N_CH-1:0] mode;
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  burst_len;
    logic              start;
    logic [N_CH-1:0]   q;
    logic              busy;

    modport master (
        output mode, period, burst_len, start,
        input  q, busy
    );

    modport slave (
        input  mode, period, burst_len, start,
        output q, busy
    );
endinterface

// File: rtl/thmitll_const_src_sync.sv
// Multi-channel RSFQ stimulus source: per channel always-0/always-1/periodic/burst, registered outputs.
// Optional THMITLL_CONST_SRC_OUTREG_EN adds a second output register stage on q and busy.
module thmitll_const_src_sync_ch #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] burst_len_i,
    input  logic             start_i,
    output logic             q_o,
    output logic             busy_o
);
    localparam logic [1:0] M_ALWAYS0  = 2'b00;
    localparam logic [1:0] M_ALWAYS1  = 2'b01;
    localparam logic [1:0] M_PERIODIC = 2'b10;
    localparam logic [1:0] M_BURST    = 2'b11;

    typedef enum logic {IDLE, RUN} st_t;

    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    st_t              st_q, st_d;
    logic             q_q, q_d;
    logic             busy_q, busy_d;

    logic [CNT_W-1:0] per_eff, lim, cnt_next;
    logic             hit;

    // Burst spacing treats period 0 as 1; a period shrunk below cnt wraps with no pulse.
    always_comb begin
        per_eff  = (period_i == '0) ? CNT_W'(1) : period_i;
        lim      = per_eff - CNT_W'(1);
        hit      = (cnt_q == lim);
        cnt_next = (hit || cnt_q >= per_eff) ? '0 : cnt_q + CNT_W'(1);
    end

    always_comb begin
        mode_d = mode_i;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        st_d   = st_q;
        q_d    = 1'b0;
        busy_d = 1'b0;
        if (mode_i != mode_q) begin
            cnt_d = '0;
            rem_d = '0;
            st_d  = IDLE;
        end else begin
            case (mode_q)
                M_ALWAYS0: ;
                M_ALWAYS1: q_d = 1'b1;
                M_PERIODIC: begin
                    if (period_i == '0) begin
                        cnt_d = '0;
                    end else begin
                        q_d   = hit;
                        cnt_d = cnt_next;
                    end
                end
                M_BURST: begin
                    if (st_q == IDLE) begin
                        if (start_i && burst_len_i != '0) begin
                            // The arming edge emits the first pulse, so rem holds what is left after it.
                            q_d    = 1'b1;
                            busy_d = 1'b1;
                            cnt_d  = '0;
                            rem_d  = burst_len_i - CNT_W'(1);
                            st_d   = (burst_len_i == CNT_W'(1)) ? IDLE : RUN;
                        end
                    end else begin
                        busy_d = 1'b1;
                        cnt_d  = cnt_next;
                        if (hit) begin
                            q_d   = 1'b1;
                            rem_d = rem_q - CNT_W'(1);
                            if (rem_q == CNT_W'(1)) st_d = IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= M_ALWAYS0;
            cnt_q  <= '0;
            rem_q  <= '0;
            st_q   <= IDLE;
            q_q    <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            st_q   <= st_d;
            q_q    <= q_d;
            busy_q <= busy_d;
        end
    end

    assign q_o    = q_q;
    assign busy_o = busy_q;
endmodule

module thmitll_const_src_sync #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    thmitll_const_src_sync_if.slave bus
);
    logic [N_CH-1:0] q_ch;
    logic [N_CH-1:0] busy_ch;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        thmitll_const_src_sync_ch #(.CNT_W(CNT_W)) u_ch (
            .clk         (clk),
            .rst         (rst),
            .mode_i      (bus.mode[2*ch +: 2]),
            .period_i    (bus.period),
            .burst_len_i (bus.burst_len),
            .start_i     (bus.start),
            .q_o         (q_ch[ch]),
            .busy_o      (busy_ch[ch])
        );
    end

`ifdef THMITLL_CONST_SRC_OUTREG_EN
    logic [N_CH-1:0] q2_q, q2_d;
    logic            busy2_q, busy2_d;

    always_comb begin
        q2_d    = q_ch;
        busy2_d = |busy_ch;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q2_q    <= '0;
            busy2_q <= 1'b0;
        end else begin
            q2_q    <= q2_d;
            busy2_q <= busy2_d;
        end
    end

    assign bus.q    = q2_q;
    assign bus.busy = busy2_q;
`else
    assign bus.q    = q_ch;
    assign bus.busy = |busy_ch;
`endif
endmodule
